// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter and its read-return tracker.
package dmem_arbiter_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  // Encoding is visible on the board display: 0 idle, 1 cpu, 2 host.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCpu  = 2'd1,
    StHost = 2'd2
  } arb_state_e;

  typedef enum logic {
    TagCpu  = 1'b0,
    TagHost = 1'b1
  } req_tag_e;

endpackage

// File: rtl/dmem_rd_tracker.sv
// Tracks the one outstanding read and steers the memory's return data to the requester.
module dmem_rd_tracker
  import dmem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_cpu,
  input  logic              rd_host,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata
);

  logic              pend_q;
  req_tag_e          tag_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  // A return in flight when reset rises is discarded.
  always_comb begin
    cpu_rvalid  = 1'b0;
    host_rvalid = 1'b0;
    if (pend_q && !reset) begin
      cpu_rvalid  = (tag_q == TagCpu);
      host_rvalid = (tag_q == TagHost);
    end
  end

  // The memory's data is presented in the return cycle and held afterwards.
  assign cpu_rdata  = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
  assign host_rdata = host_rvalid ? mem_rdata : host_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= 1'b0;
      tag_q        <= TagCpu;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      pend_q <= rd_cpu | rd_host;
      tag_q  <= rd_host ? TagHost : TagCpu;
      if (cpu_rvalid) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (host_rvalid) begin
        host_rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: processor has priority, host is forced a grant after starving.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        arb_state
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_MAX);

  arb_state_e state_q;
  logic [3:0] starve_q;
  logic       host_force;
  logic       cpu_gnt;
  logic       host_gnt;

  assign host_force = host_req && (starve_q == StarveLimit);

  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (!reset) begin
      if (host_force) begin
        host_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (host_req) begin
        host_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wr    = cpu_wr;
    end else if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_wr    = host_wr;
    end
  end

  assign cpu_ack   = cpu_gnt;
  assign host_ack  = host_gnt;
  assign arb_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      starve_q <= '0;
    end else begin
      unique case ({host_gnt, cpu_gnt})
        2'b01:   state_q <= StCpu;
        2'b10:   state_q <= StHost;
        default: state_q <= StIdle;
      endcase
      if (!host_req || host_gnt) begin
        starve_q <= '0;
      end else if (starve_q != StarveLimit) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end

  dmem_rd_tracker u_rd_tracker (
    .clk        (clk),
    .reset      (reset),
    .rd_cpu     (cpu_gnt & ~cpu_wr),
    .rd_host    (host_gnt & ~host_wr),
    .mem_rdata  (mem_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata)
  );

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, 4, consecutive host-denied cycles before the host is forced a grant (range 1-15).
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cpu_req  in  1  processor requests a data-memory access.
REQ-005 cpu_wr  in  1  1 = write, 0 = read (processor).
REQ-006 cpu_addr  in  8  processor data-memory address.
REQ-007 cpu_wdata  in  16  processor write data.
REQ-008 cpu_ack  out  1  processor access accepted this cycle.
REQ-009 cpu_rvalid  out  1  processor read data valid.
REQ-010 cpu_rdata  out  16  processor read data.
REQ-011 host_req, host_wr, host_addr[8], host_wdata[16]  in  host/debug port request, same meaning as cpu_*.
REQ-012 host_ack, host_rvalid, host_rdata[16]  out  host/debug port responses, same meaning as cpu_*.
REQ-013 mem_addr  out  8  address to 256x16 data memory.
REQ-014 mem_wdata  out  16  write data to memory.
REQ-015 mem_wr  out  1  memory write enable.
REQ-016 mem_rdata  in  16  memory read data, valid one cycle after address presented.
REQ-017 arb_state  out  2  current FSM state for board display (0 IDLE, 1 CPU, 2 HOST).

Function
REQ-018 One memory access SHALL be issued per cycle at most; ack, mem_addr, mem_wdata, mem_wr combinational from the granted requester in the accept cycle.
REQ-019 Requester SHALL hold req/wr/addr/wdata stable until ack; arbiter SHALL accept one access per ack, back-to-back acks allowed every cycle.
REQ-020 mem_wr = 1 only in a cycle where the granted access has wr=1; otherwise 0; mem_addr/mem_wdata = 0 when no grant.
REQ-021 Priority: cpu_req wins over host_req unless starve count == STARVE_MAX, then host wins that cycle.
REQ-022 Starve counter: +1 each cycle host_req=1 and host not granted; clears when host granted or host_req=0; saturates at STARVE_MAX.
REQ-023 Read accepted in cycle N SHALL give <req>_rvalid=1 in cycle N+1 for that requester only, with <req>_rdata = mem_rdata in N+1; other requester's rvalid stays 0.
REQ-024 <req>_rdata SHALL be registered and hold its last value until the next read return for that requester.
REQ-025 FSM states IDLE, CPU, HOST; next state = CPU on cpu grant, HOST on host grant, IDLE on no grant; arb_state = registered current state.
REQ-026 Writes SHALL produce no rvalid.
REQ-027 Total latency: write 0 cycles (ack same cycle), read 1 cycle to rvalid.

Reset
REQ-028 While reset=1: cpu_ack, host_ack, mem_wr = 0 combinationally; no access accepted.
REQ-029 On reset edge: state IDLE, arb_state 0, starve count 0, rvalid both 0, rdata both 0x0000.
REQ-030 A read accepted the cycle before reset asserted SHALL NOT produce rvalid.

Structure
REQ-031 Shared package SHALL hold state enum (IDLE, CPU, HOST), ADDR_W=8, DATA_W=16.
REQ-032 Read-return tracking (pending flag, requester tag, rdata regs) SHALL be sub-module dmem_rd_tracker; arbitration and FSM in dmem_arbiter.

Verification
REQ-033 Assert reset 2 cycles -> all outputs 0, arb_state 0.
REQ-034 cpu write addr 0x01 data 0x00AB -> same cycle cpu_ack=1, mem_wr=1, mem_addr=0x01; then cpu read 0x01 -> next cycle cpu_rvalid=1, cpu_rdata=0x00AB, host_rvalid=0.
REQ-035 cpu_req and host_req held high continuously, STARVE_MAX=4 -> cpu acked cycles 1-4, host acked cycle 5, cpu cycle 6, pattern repeats; arb_state follows grants.
REQ-036 host read 0x10 only, memory holding 0x1234 -> host_ack same cycle, host_rvalid next cycle, host_rdata=0x1234, cpu_rvalid=0.
REQ-037 cpu write 0x05 and host read 0x05 same cycle -> cpu acked first, host acked next cycle, host_rdata = new cpu data.
REQ-038 cpu read accepted, reset high next cycle -> cpu_rvalid=0, cpu_rdata=0x0000, arb_state 0.
